// File: rtl/pmc_ac_shadow_pkg.sv
// Shared types and constants for the PMC analog-configuration shadow block.
package pmc_ac_shadow_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPending,
    StSettle
  } fsm_state_e;

  // CTRL register bit positions
  localparam int unsigned CtrlCommit  = 0;
  localparam int unsigned CtrlLock    = 1;
  localparam int unsigned CtrlPending = 8;
  localparam int unsigned CtrlTimeout = 9;

  // Expand 4 byte enables into a 32-bit write mask
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/pmc_ac_shadow_fsm.sv
// Commit/apply sequencer: waits for the PMU safe window, times out, then settles.
module pmc_ac_shadow_fsm
  import pmc_ac_shadow_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned SETTLE_CYCLES  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic commit_req_i,
  input  logic apply_ok_i,
  output logic apply_o,
  output logic busy_o,
  output logic timeout_set_o
);

  localparam int unsigned MaxCnt = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES
                                                                     : SETTLE_CYCLES;
  localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] SettleLast  = CntW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  fsm_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic            busy_q;

  assign apply_o       = (state_q == StPending) && apply_ok_i;
  assign timeout_set_o = (state_q == StPending) && !apply_ok_i && (cnt_q == TimeoutLast);
  assign busy_o        = busy_q;

  // State, counter and registered busy flag; the counter stops at its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (commit_req_i) begin
            state_q <= StPending;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StPending: begin
          if (apply_ok_i) begin
            cnt_q <= '0;
            if (SETTLE_CYCLES > 0) begin
              state_q <= StSettle;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end else if (cnt_q == TimeoutLast) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StSettle: begin
          if (cnt_q == SettleLast) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pmc_ac_shadow.sv
// Shadowed analog-config register bank with atomic commit into the active outputs.
module pmc_ac_shadow
  import pmc_ac_shadow_pkg::*;
#(
  parameter int unsigned          NUM_REGS       = 4,
  parameter int unsigned          TIMEOUT_CYCLES = 1024,
  parameter int unsigned          SETTLE_CYCLES  = 8,
  parameter logic [NUM_REGS*32-1:0] RESET_VAL    = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req,
  output logic                     gnt,
  input  logic [31:0]              addr,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [31:0]              wdata,
  output logic                     rvalid,
  output logic [31:0]              rdata,
  output logic                     err,
  input  logic                     apply_ok_i,
  output logic [NUM_REGS*32-1:0]   cfg_o,
  output logic                     cfg_update_o,
  output logic                     busy_o
);

  localparam int unsigned        OffsW    = $clog2(NUM_REGS + 1);
  localparam logic [OffsW-1:0]   CtrlOffs = OffsW'(NUM_REGS);

  logic [NUM_REGS*32-1:0] shadow_q, shadow_d, cfg_q;
  logic                   rvalid_q, err_q, upd_q, lock_q, timeout_q, commit_q;
  logic [31:0]            rdata_q, rdata_d, shadow_rd, ctrl_rd, wr_mask;
  logic [OffsW-1:0]       offset;
  logic is_shadow, is_ctrl, oob;
  logic sh_wr, sh_wr_err, sh_wr_ok, ctrl_wr, commit_bit, commit_lock_err, ctrl_ok;
  logic acc_err, commit_acc, lock_set, timeout_clr, apply, timeout_set;

  logic unused_addr;
  assign unused_addr = ^{addr[31:OffsW+2], addr[1:0]};

  assign gnt       = req;
  assign offset    = addr[OffsW+1:2];
  assign is_shadow = offset < CtrlOffs;
  assign is_ctrl   = offset == CtrlOffs;
  assign oob       = offset > CtrlOffs;
  assign wr_mask   = be_mask(be);

  // Access decode: errors leave all state untouched
  assign sh_wr           = req && we && is_shadow;
  assign sh_wr_err       = sh_wr && (lock_q || busy_o);
  assign sh_wr_ok        = sh_wr && !sh_wr_err;
  assign ctrl_wr         = req && we && is_ctrl;
  assign commit_bit      = be[0] && wdata[CtrlCommit];
  assign commit_lock_err = ctrl_wr && commit_bit && lock_q;
  assign ctrl_ok         = ctrl_wr && !commit_lock_err;
  assign acc_err         = req && (oob || sh_wr_err || commit_lock_err);
  // A commit while the sequencer is busy is silently dropped
  assign commit_acc      = ctrl_ok && commit_bit && !busy_o;
  assign lock_set        = ctrl_ok && be[0] && wdata[CtrlLock];
  assign timeout_clr     = ctrl_ok && be[1] && wdata[CtrlTimeout];

  // Shadow read mux and byte-masked shadow write
  always_comb begin
    shadow_rd = '0;
    shadow_d  = shadow_q;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (offset == OffsW'(k)) begin
        shadow_rd = shadow_q[32*k +: 32];
        if (sh_wr_ok) begin
          shadow_d[32*k +: 32] = (shadow_q[32*k +: 32] & ~wr_mask) | (wdata & wr_mask);
        end
      end
    end
  end

  // CTRL status and read-data selection; writes and errors return zero
  always_comb begin
    ctrl_rd              = '0;
    ctrl_rd[CtrlLock]    = lock_q;
    ctrl_rd[CtrlPending] = busy_o;
    ctrl_rd[CtrlTimeout] = timeout_q;
    rdata_d              = '0;
    if (req && !we && !acc_err) begin
      rdata_d = is_ctrl ? ctrl_rd : shadow_rd;
    end
  end

  // Commit is registered once so the earliest apply lands two edges after the grant
  pmc_ac_shadow_fsm #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SETTLE_CYCLES  (SETTLE_CYCLES)
  ) u_fsm (
    .clk           (clk),
    .rst_n         (rst_n),
    .commit_req_i  (commit_q),
    .apply_ok_i    (apply_ok_i),
    .apply_o       (apply),
    .busy_o        (busy_o),
    .timeout_set_o (timeout_set)
  );

  // Bus response, register bank, active config and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      shadow_q  <= RESET_VAL;
      cfg_q     <= RESET_VAL;
      upd_q     <= 1'b0;
      lock_q    <= 1'b0;
      timeout_q <= 1'b0;
      commit_q  <= 1'b0;
    end else begin
      rvalid_q  <= req;
      rdata_q   <= rdata_d;
      err_q     <= acc_err;
      shadow_q  <= shadow_d;
      if (apply) begin
        cfg_q <= shadow_q;
      end
      upd_q     <= apply;
      lock_q    <= lock_q || lock_set;
      timeout_q <= timeout_set || (timeout_q && !timeout_clr);
      commit_q  <= commit_acc;
    end
  end

  assign rvalid       = rvalid_q;
  assign rdata        = rdata_q;
  assign err          = err_q;
  assign cfg_o        = cfg_q;
  assign cfg_update_o = upd_q;

endmodule

// File: tb/tb_pmc_ac_shadow.sv
// Self-checking bench for pmc_ac_shadow: vector table, directed sequences, random traffic.
module tb_pmc_ac_shadow;

  localparam int unsigned NRegs   = 4;
  localparam int unsigned Timeout = 16;
  localparam int unsigned Settle  = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req = 1'b0, we = 1'b0, apply_ok = 1'b0;
  logic [31:0]  addr = '0, wdata = '0;
  logic [3:0]   be = '0;
  logic         gnt, rvalid, err, cfg_update, busy;
  logic [31:0]  rdata;
  logic [127:0] cfg;

  int n_checks = 0;
  int n_err    = 0;

  pmc_ac_shadow #(
    .NUM_REGS       (NRegs),
    .TIMEOUT_CYCLES (Timeout),
    .SETTLE_CYCLES  (Settle),
    .RESET_VAL      ('0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .gnt          (gnt),
    .addr         (addr),
    .we           (we),
    .be           (be),
    .wdata        (wdata),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .err          (err),
    .apply_ok_i   (apply_ok),
    .cfg_o        (cfg),
    .cfg_update_o (cfg_update),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: register contents plus deadline-style sequencer bookkeeping
  logic [31:0] m_sh [4];
  logic [31:0] m_cfg [4];
  logic        m_lock, m_tmo, m_commit_seen, m_pend;
  int          m_pend_age, m_settle_left;
  logic        e_rvalid, e_err, e_upd, e_busy;
  logic [31:0] e_rdata;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_sh[i]  = '0;
      m_cfg[i] = '0;
    end
    m_lock = 0; m_tmo = 0; m_commit_seen = 0; m_pend = 0;
    m_pend_age = 0; m_settle_left = 0;
    e_rvalid = 0; e_err = 0; e_upd = 0; e_busy = 0; e_rdata = '0;
  endtask

  task automatic model_step(input logic r, input logic w, input logic [2:0] off,
                            input logic [3:0] b, input logic [31:0] wd, input logic ap);
    logic        bsy, commit, new_commit;
    logic [31:0] mask;
    bsy = m_pend || (m_settle_left != 0);
    for (int i = 0; i < 4; i++) mask[8*i +: 8] = b[i] ? 8'hFF : 8'h00;
    e_rvalid = r; e_rdata = '0; e_err = 0; e_upd = 0; new_commit = 0;
    if (r) begin
      if (off > 3'd4) begin
        e_err = 1;
      end else if (off < 3'd4) begin
        if (!w) e_rdata = m_sh[off[1:0]];
        else if (m_lock || bsy) e_err = 1;
        else m_sh[off[1:0]] = (m_sh[off[1:0]] & ~mask) | (wd & mask);
      end else begin
        commit = b[0] && wd[0];
        if (!w) begin
          e_rdata = (32'(m_tmo) << 9) | (32'(bsy) << 8) | (32'(m_lock) << 1);
        end else if (commit && m_lock) begin
          e_err = 1;
        end else begin
          if (b[0] && wd[1]) m_lock = 1;
          if (b[1] && wd[9]) m_tmo = 0;
          if (commit && !bsy) new_commit = 1;
        end
      end
    end
    if (m_pend) begin
      if (ap) begin
        for (int i = 0; i < 4; i++) m_cfg[i] = m_sh[i];
        e_upd = 1; m_pend = 0; m_settle_left = Settle;
      end else begin
        m_pend_age++;
        if (m_pend_age == Timeout) begin
          m_pend = 0; m_tmo = 1;
        end
      end
    end else if (m_settle_left > 0) begin
      m_settle_left--;
    end else if (m_commit_seen) begin
      m_pend = 1; m_pend_age = 0;
    end
    m_commit_seen = new_commit;
    e_busy = m_pend || (m_settle_left != 0);
  endtask

  // One bus cycle: drive at negedge, step the model at the edge, compare just after it
  task automatic cycle(input logic r, input logic w, input logic [2:0] off,
                       input logic [3:0] b, input logic [31:0] wd, input logic ap);
    @(negedge clk);
    req = r; we = w; be = b; wdata = wd; apply_ok = ap;
    addr = ($urandom() & 32'hFFFF_FFE3) | {27'd0, off, 2'b00};
    #1 chk("gnt", 128'(gnt), 128'(r));
    @(posedge clk);
    model_step(r, w, off, b, wd, ap);
    #1;
    chk("rvalid", 128'(rvalid), 128'(e_rvalid));
    chk("rdata", 128'(rdata), 128'(e_rdata));
    chk("err", 128'(err), 128'(e_err));
    chk("cfg_update", 128'(cfg_update), 128'(e_upd));
    chk("busy", 128'(busy), 128'(e_busy));
    chk("cfg", cfg, {m_cfg[3], m_cfg[2], m_cfg[1], m_cfg[0]});
  endtask

  task automatic idle(input logic ap);
    cycle(1'b0, 1'b0, 3'd0, 4'h0, 32'h0, ap);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = 0; apply_ok = 0; rst_n = 0;
    #1;
    chk("rst_gnt", 128'(gnt), 128'(0));
    chk("rst_rvalid", 128'(rvalid), 128'(0));
    chk("rst_rdata", 128'(rdata), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_upd", 128'(cfg_update), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_cfg", cfg, 128'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  off;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam logic [127:0] CfgApplied =
    {32'hDE00_BE00, 32'hA5A5_0001, 32'h00CC_0077, 32'h0000_0000};

  initial begin
    vec_t vecs[$];
    vecs.push_back('{1'b1, 3'd2, 4'hF, 32'hA5A5_0001, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 3'd2, 4'hF, 32'h0,         1'b0, 32'hA5A5_0001});
    vecs.push_back('{1'b1, 3'd1, 4'h4, 32'h00CC_0000, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 3'd1, 4'hF, 32'h0,         1'b0, 32'h00CC_0000});
    vecs.push_back('{1'b0, 3'd5, 4'hF, 32'h0,         1'b1, 32'h0});
    vecs.push_back('{1'b1, 3'd1, 4'h1, 32'hFFFF_FF77, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 3'd1, 4'hF, 32'h0,         1'b0, 32'h00CC_0077});
    vecs.push_back('{1'b1, 3'd6, 4'hF, 32'h1234_5678, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 3'd7, 4'hF, 32'h0,         1'b1, 32'h0});
    vecs.push_back('{1'b0, 3'd4, 4'hF, 32'h0,         1'b0, 32'h0});
    vecs.push_back('{1'b1, 3'd3, 4'hA, 32'hDEAD_BEEF, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 3'd3, 4'hF, 32'h0,         1'b0, 32'hDE00_BE00});

    model_reset();
    do_reset();

    // Register accesses from the table
    foreach (vecs[i]) begin
      cycle(1'b1, vecs[i].we, vecs[i].off, vecs[i].be, vecs[i].wdata, 1'b0);
      chk($sformatf("vec%0d_err", i), 128'(err), 128'(vecs[i].exp_err));
      if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), 128'(rdata), 128'(vecs[i].exp_rdata));
    end
    chk("cfg_untouched", cfg, 128'(0));

    // Commit, delayed safe window, settle
    cycle(1'b1, 1'b1, 3'd4, 4'h1, 32'h1, 1'b0);
    chk("commit_err", 128'(err), 128'(0));
    idle(1'b0);
    chk("busy_t1", 128'(busy), 128'(1));
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    chk("apply_cfg", cfg, CfgApplied);
    chk("apply_pulse", 128'(cfg_update), 128'(1));
    for (int i = 0; i < 7; i++) begin
      idle(1'b0);
      chk("settle_busy", 128'(busy), 128'(1));
      chk("single_pulse", 128'(cfg_update), 128'(0));
    end
    idle(1'b0);
    chk("settle_done", 128'(busy), 128'(0));

    // Timeout with the safe window never opening
    cycle(1'b1, 1'b1, 3'd4, 4'h1, 32'h1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      idle(1'b0);
      chk("pend_busy", 128'(busy), 128'(1));
    end
    idle(1'b0);
    chk("timeout_idle", 128'(busy), 128'(0));
    cycle(1'b1, 1'b0, 3'd4, 4'hF, 32'h0, 1'b0);
    chk("timeout_ctrl", 128'(rdata), 128'(32'h0000_0200));
    chk("timeout_cfg", cfg, CfgApplied);
    cycle(1'b1, 1'b1, 3'd4, 4'h2, 32'h200, 1'b0);
    cycle(1'b1, 1'b0, 3'd4, 4'hF, 32'h0, 1'b0);
    chk("timeout_clr", 128'(rdata), 128'(0));

    // Shadow write and second commit while pending
    cycle(1'b1, 1'b1, 3'd4, 4'h1, 32'h1, 1'b0);
    idle(1'b0);
    cycle(1'b1, 1'b1, 3'd0, 4'hF, 32'h1234_5678, 1'b0);
    chk("busy_wr_err", 128'(err), 128'(1));
    cycle(1'b1, 1'b1, 3'd4, 4'h1, 32'h1, 1'b0);
    chk("busy_commit_err", 128'(err), 128'(0));
    cycle(1'b1, 1'b0, 3'd4, 4'hF, 32'h0, 1'b0);
    chk("busy_ctrl", 128'(rdata), 128'(32'h0000_0100));
    cycle(1'b1, 1'b0, 3'd0, 4'hF, 32'h0, 1'b0);
    chk("busy_wr_dropped", 128'(rdata), 128'(0));
    idle(1'b1);
    chk("busy_apply_pulse", 128'(cfg_update), 128'(1));
    for (int i = 0; i < 8; i++) idle(1'b0);
    chk("busy_settle_done", 128'(busy), 128'(0));

    // Lock together with a commit, then locked accesses, then reset mid-pending
    cycle(1'b1, 1'b1, 3'd4, 4'h1, 32'h3, 1'b0);
    chk("lock_commit_err", 128'(err), 128'(0));
    idle(1'b0);
    cycle(1'b1, 1'b1, 3'd2, 4'hF, 32'hFFFF_FFFF, 1'b0);
    chk("lock_wr_err", 128'(err), 128'(1));
    cycle(1'b1, 1'b1, 3'd4, 4'h1, 32'h1, 1'b0);
    chk("lock_commit2_err", 128'(err), 128'(1));
    cycle(1'b1, 1'b0, 3'd4, 4'hF, 32'h0, 1'b0);
    chk("lock_ctrl", 128'(rdata), 128'(32'h0000_0102));
    do_reset();
    cycle(1'b1, 1'b0, 3'd4, 4'hF, 32'h0, 1'b0);
    chk("post_rst_ctrl", 128'(rdata), 128'(0));
    cycle(1'b1, 1'b0, 3'd2, 4'hF, 32'h0, 1'b0);
    chk("post_rst_shadow", 128'(rdata), 128'(0));

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic        r, w, ap;
      logic [2:0]  off;
      logic [31:0] wd;
      if (n == 300) do_reset();
      r   = $urandom_range(0, 3) != 0;
      w   = $urandom_range(0, 1) == 1;
      off = ($urandom_range(0, 4) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
      wd  = $urandom();
      if (off == 3'd4 && $urandom_range(0, 40) != 0) wd = wd & 32'hFFFF_FFFD;
      ap  = $urandom_range(0, 7) == 0;
      cycle(r, w, off, 4'($urandom_range(0, 15)), wd, ap);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pmc_ac_shadow.md
Name: pmc_ac_shadow

Overview:
- Parametrised successor of the PMC analog-configuration register block. Sits on the Ibex data bus, inside the PMC, and drives the PM analog configuration bus.
- Bus writes go to shadow registers. A COMMIT request transfers all shadow registers atomically to the active outputs, but only when the PMU signals a safe window (apply_ok_i).
- Adds a post-apply settle interval, a timeout with sticky error, a write lock, byte enables and an error response.

Parameters:
- NUM_REGS, 4, number of 32-bit config registers; range 1..64.
- TIMEOUT_CYCLES, 1024, maximum PENDING cycles before abort; must be ≥1.
- SETTLE_CYCLES, 8, cycles after an apply before a new commit is accepted; 0 allowed.
- RESET_VAL, '0 (NUM_REGS*32 bits), reset value of the shadow and active registers.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  1  bus request
- gnt  out  1  bus grant
- addr  in  32  byte address; offset = addr[OFFS_W+1:2], where OFFS_W = $clog2(NUM_REGS+1)
- we  in  1  write enable
- be  in  4  byte enables
- wdata  in  32  write data
- rvalid  out  1  response valid
- rdata  out  32  read data
- err  out  1  error response, valid with rvalid
- apply_ok_i  in  1  PMU safe-window indication
- cfg_o  out  NUM_REGS*32  active configuration; reg k maps to bits [32k+31:32k]
- cfg_update_o  out  1  one-cycle pulse when cfg_o changes
- busy_o  out  1  FSM not IDLE

Behaviour:
- Reset values:
  - gnt=0, rvalid=0, rdata=0, err=0, cfg_update_o=0, busy_o=0.
  - cfg_o=RESET_VAL, shadow=RESET_VAL.
  - LOCK=0, TIMEOUT flag=0, FSM=IDLE, counter=0.
- Handshake:
  - gnt = req, combinationally.
  - The access takes effect at the granting edge.
  - rvalid pulses exactly one cycle after each grant, with rdata and err registered.
  - Back-to-back requests are supported, one per cycle.
- Address map (word offsets):
  - 0..NUM_REGS-1: shadow registers, R/W, byte-enable masked.
  - NUM_REGS: CTRL register.
    - Bit 0 COMMIT: write-1 triggers a commit; reads 0.
    - Bit 1 LOCK: write-1 sets it; it stays set until reset.
    - Bit 8 PENDING: read-only, equals busy_o.
    - Bit 9 TIMEOUT: sticky; write-1 clears it.
    - All other bits read 0.
  - CTRL bits 0–1 take effect only if be[0]=1; bit 9 only if be[1]=1.
- Errors: err=1 with rdata=0 and no state change for any of:
  - offset > NUM_REGS;
  - a write to a shadow register while LOCK=1;
  - a write to a shadow register while the FSM is not IDLE;
  - a CTRL write with COMMIT=1 while LOCK=1.
- CTRL writes that only set LOCK or clear TIMEOUT are always accepted.
- Reads return shadow contents (not cfg_o) or CTRL status. A read in the cycle of a write returns the pre-write value.
- FSM transitions:
  - IDLE → PENDING on an accepted COMMIT write; the counter is cleared.
  - PENDING, apply_ok_i=1 at an edge:
    - cfg_o <= shadow and cfg_update_o=1 for the next cycle.
    - Go to SETTLE if SETTLE_CYCLES>0, else IDLE.
  - PENDING, apply_ok_i=0: the counter increments. When it reaches TIMEOUT_CYCLES-1 with apply_ok_i still low:
    - set TIMEOUT, go to IDLE;
    - cfg_o is unchanged and no pulse is issued.
  - SETTLE: count SETTLE_CYCLES cycles, then go to IDLE.
  - COMMIT written while not IDLE: ignored, err=0.
- Latency: COMMIT granted at edge t gives PENDING from t+1. If apply_ok_i is already high, the apply edge is t+2 at the earliest.
- apply_ok_i in IDLE or SETTLE has no effect.
- Reset mid-PENDING or mid-SETTLE: FSM returns to IDLE, and cfg_o and shadow go to RESET_VAL.
- The counter width is derived from max(TIMEOUT_CYCLES, SETTLE_CYCLES) and never wraps.

Decomposition:
- Package pmc_ac_shadow_pkg holds:
  - FSM state enum (IDLE, PENDING, SETTLE);
  - CTRL bit-index localparams (COMMIT=0, LOCK=1, PENDING=8, TIMEOUT=9);
  - a byte-enable mask function.
- Sub-module pmc_ac_shadow_fsm: commit/apply FSM and counter. Inputs: commit_req, apply_ok_i. Outputs: apply strobe, busy, timeout_set.

Test Plan:
1. NUM_REGS=4: write 0xA5A5_0001 to offset 2 with be=4'hF, then read offset 2. Required: rdata=0xA5A5_0001, err=0, and cfg_o[95:64] still 0.
2. Write offset 1 with be=4'b0100 and wdata=0x00CC_0000, then read. Required: rdata=0x00CC_0000. Read offset 5. Required: err=1, rdata=0.
3. Write COMMIT, hold apply_ok_i=0 for 3 cycles, then raise it. Required:
   - busy_o high from t+1;
   - cfg_o equals shadow one cycle after the apply edge, with a single cfg_update_o pulse;
   - busy_o drops 8 cycles later.
4. Run with TIMEOUT_CYCLES=16 and apply_ok_i=0 throughout a commit. Required:
   - busy_o drops after 16 cycles, CTRL read=0x0000_0200, cfg_o unchanged;
   - writing 0x200 to CTRL then reading it returns 0.
5. Write a shadow register and COMMIT while PENDING. Required: err=1 on the shadow write, err=0 on the COMMIT, and the FSM is unaffected.
6. Set LOCK, then write a shadow register and COMMIT. Required: both err=1, with LOCK still set. Asserting rst_n low mid-PENDING returns all outputs to their reset values.
